// File: rtl/smooth_oscillator_serdes_if.sv
// Control and parallel-word bus between the period controller, the square-wave
// generator and the downstream OSERDES. CE is shared with the serializer.
interface smooth_oscillator_serdes_if #(
  parameter int SERDES_WIDTH = 8,
  parameter int HP_WIDTH     = 30
);
  logic                    CE;
  logic                    ENABLE;
  logic [HP_WIDTH-1:0]     HALF_PERIOD_IN;
  logic                    HALF_PERIOD_VALID;
  logic [SERDES_WIDTH-1:0] OUT_WORD;
  logic                    EDGE;
  logic                    RUNNING;
  logic [HP_WIDTH-1:0]     HALF_PERIOD_CUR;

  modport master (
    output CE, ENABLE, HALF_PERIOD_IN, HALF_PERIOD_VALID,
    input  OUT_WORD, EDGE, RUNNING, HALF_PERIOD_CUR
  );

  modport slave (
    input  CE, ENABLE, HALF_PERIOD_IN, HALF_PERIOD_VALID,
    output OUT_WORD, EDGE, RUNNING, HALF_PERIOD_CUR
  );
endinterface

// File: rtl/smooth_oscillator_serdes.sv
// Fixed-point square-wave generator emitting SERDES_WIDTH slots per CLK with a
// clamped, IIR-smoothed half-period and glitch-free start/stop gating.
module smooth_oscillator_serdes #(
  parameter int SERDES_WIDTH      = 8,
  parameter int PERIOD_INT_PART   = 10,
  parameter int PERIOD_FRAC_PART  = 20,
  parameter int PERIOD_MIN        = 8,
  parameter int PERIOD_MAX        = 1000,
  parameter int FILTER_SHIFT      = 4,
  parameter int HALF_PERIOD_RESET = 100 << PERIOD_FRAC_PART
) (
  input  logic                        CLK,
  input  logic                        RESET,
  smooth_oscillator_serdes_if.slave   bus
);

  localparam int HPW   = PERIOD_INT_PART + PERIOD_FRAC_PART;
  localparam int PW    = HPW + 1;
  localparam int LOG2N = $clog2(SERDES_WIDTH);
  localparam int F     = PERIOD_FRAC_PART;

  localparam logic [PW-1:0]  NW       = PW'(SERDES_WIDTH << PERIOD_FRAC_PART);
  localparam logic [HPW-1:0] HP_MIN   = HPW'(PERIOD_MIN << PERIOD_FRAC_PART);
  localparam logic [HPW-1:0] HP_MAX   = HPW'(PERIOD_MAX << PERIOD_FRAC_PART);
  localparam logic [HPW-1:0] HP_RESET = HPW'(HALF_PERIOD_RESET);
  localparam logic [PW-1:0]  SNAP     = PW'(1) << FILTER_SHIFT;

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t                    fsm_q, fsm_d;
  logic                    level_q, level_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [HPW-1:0]          target_q, target_d;
  logic [HPW-1:0]          half_q, half_d;
  logic [SERDES_WIDTH-1:0] out_word_q, out_word_d;
  logic                    edge_q, edge_d;

  logic [HPW-1:0]          clamped;
  logic [PW-1:0]           half_minus_nw;
  logic signed [PW-1:0]    diff;
  logic signed [PW-1:0]    step;
  logic signed [PW-1:0]    sum;
  logic [PW-1:0]           abs_diff;
  logic [HPW-1:0]          half_smoothed;
  logic [LOG2N-1:0]        edge_slot;
  logic [SERDES_WIDTH-1:0] edge_word;

  // Datapath shared by both FSM states: clamp, smoothing step and edge word.
  always_comb begin
    clamped = bus.HALF_PERIOD_IN;
    if (bus.HALF_PERIOD_IN < HP_MIN)
      clamped = HP_MIN;
    else if (bus.HALF_PERIOD_IN > HP_MAX)
      clamped = HP_MAX;

    half_minus_nw = {1'b0, half_q} - NW;

    diff     = $signed({1'b0, target_q}) - $signed({1'b0, half_q});
    step     = diff >>> FILTER_SHIFT;
    sum      = $signed({1'b0, half_q}) + step;
    abs_diff = diff[PW-1] ? -diff : diff;
    half_smoothed = (abs_diff < SNAP) ? target_q : HPW'(sum);

    edge_slot = phase_q[F+LOG2N-1:F];
    edge_word = '0;
    for (int j = 0; j < SERDES_WIDTH; j++)
      edge_word[j] = (LOG2N'(j) < edge_slot) ? level_q : ~level_q;
  end

  // Next state: the edge uses the pre-update half-period, the new one applies afterwards.
  always_comb begin
    fsm_d      = fsm_q;
    level_d    = level_q;
    phase_d    = phase_q;
    target_d   = target_q;
    half_d     = half_q;
    out_word_d = out_word_q;
    edge_d     = edge_q;

    if (bus.CE) begin
      if (bus.HALF_PERIOD_VALID)
        target_d = clamped;
      edge_d = 1'b0;

      unique case (fsm_q)
        IDLE: begin
          out_word_d = '0;
          level_d    = 1'b0;
          phase_d    = '0;
          if (bus.ENABLE) begin
            fsm_d      = RUN;
            out_word_d = '1;
            level_d    = 1'b1;
            edge_d     = 1'b1;
            phase_d    = half_minus_nw;
            half_d     = half_smoothed;
          end
        end
        RUN: begin
          if (!bus.ENABLE && !level_q) begin
            fsm_d      = IDLE;
            out_word_d = '0;
            phase_d    = '0;
          end else if (phase_q < NW) begin
            out_word_d = edge_word;
            level_d    = ~level_q;
            edge_d     = 1'b1;
            phase_d    = phase_q + half_minus_nw;
            half_d     = half_smoothed;
            // A stop request while high ends here, after the falling edge.
            if (!bus.ENABLE) begin
              fsm_d   = IDLE;
              phase_d = '0;
            end
          end else begin
            out_word_d = {SERDES_WIDTH{level_q}};
            phase_d    = phase_q - NW;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fsm_q      <= IDLE;
      level_q    <= 1'b0;
      phase_q    <= '0;
      target_q   <= HP_RESET;
      half_q     <= HP_RESET;
      out_word_q <= '0;
      edge_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      level_q    <= level_d;
      phase_q    <= phase_d;
      target_q   <= target_d;
      half_q     <= half_d;
      out_word_q <= out_word_d;
      edge_q     <= edge_d;
    end
  end

  assign bus.OUT_WORD        = out_word_q;
  assign bus.EDGE            = edge_q;
  assign bus.RUNNING         = (fsm_q == RUN);
  assign bus.HALF_PERIOD_CUR = half_q;

endmodule

// File: tb/tb_smooth_oscillator_serdes.sv
// Directed bench: dut_a (N=8, F=4, no smoothing) covers waveform, CE, stop, reset,
// dithering and clamping; dut_b (FILTER_SHIFT=2) covers the IIR smoothing.
module tb_smooth_oscillator_serdes;

  localparam int N  = 8;
  localparam int F  = 4;
  localparam int IA = 13;
  localparam int IB = 10;

  logic CLK = 1'b0;
  logic RESET;
  int   vectors = 0;
  int   miscompares = 0;

  // H = 10.0 slots: repeating words and edge flags.
  logic [7:0] int_words [5] = '{8'hFF, 8'h03, 8'hF0, 8'h3F, 8'h00};
  logic       int_edges [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 CLK = ~CLK;

  smooth_oscillator_serdes_if #(.SERDES_WIDTH(N), .HP_WIDTH(IA+F)) bus_a ();
  smooth_oscillator_serdes_if #(.SERDES_WIDTH(N), .HP_WIDTH(IB+F)) bus_b ();

  smooth_oscillator_serdes #(
    .SERDES_WIDTH(N), .PERIOD_INT_PART(IA), .PERIOD_FRAC_PART(F),
    .PERIOD_MIN(8), .PERIOD_MAX(1000), .FILTER_SHIFT(0), .HALF_PERIOD_RESET(160)
  ) dut_a (.CLK(CLK), .RESET(RESET), .bus(bus_a.slave));

  smooth_oscillator_serdes #(
    .SERDES_WIDTH(N), .PERIOD_INT_PART(IB), .PERIOD_FRAC_PART(F),
    .PERIOD_MIN(8), .PERIOD_MAX(1000), .FILTER_SHIFT(2), .HALF_PERIOD_RESET(1600)
  ) dut_b (.CLK(CLK), .RESET(RESET), .bus(bus_b.slave));

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    step();
    step();
    vectors++;
    if (bus_a.OUT_WORD !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_word: got %h, expected 00", bus_a.OUT_WORD); end
    vectors++;
    if (bus_a.EDGE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_edge: got %b, expected 0", bus_a.EDGE); end
    vectors++;
    if (bus_a.RUNNING !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_running: got %b, expected 0", bus_a.RUNNING); end
    vectors++;
    if (bus_a.HALF_PERIOD_CUR !== 17'd160) begin miscompares++; $display("[TB] FAIL reset_cur_a: got %0d, expected 160", bus_a.HALF_PERIOD_CUR); end
    vectors++;
    if (bus_b.HALF_PERIOD_CUR !== 14'd1600) begin miscompares++; $display("[TB] FAIL reset_cur_b: got %0d, expected 1600", bus_b.HALF_PERIOD_CUR); end
    RESET = 1'b0;
  endtask

  task automatic test_integer();
    bus_a.ENABLE = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      vectors++;
      if (bus_a.OUT_WORD !== int_words[i%5]) begin miscompares++; $display("[TB] FAIL int_word[%0d]: got %h, expected %h", i, bus_a.OUT_WORD, int_words[i%5]); end
      vectors++;
      if (bus_a.EDGE !== int_edges[i%5]) begin miscompares++; $display("[TB] FAIL int_edge[%0d]: got %b, expected %b", i, bus_a.EDGE, int_edges[i%5]); end
      vectors++;
      if (bus_a.RUNNING !== 1'b1) begin miscompares++; $display("[TB] FAIL int_running[%0d]: got %b, expected 1", i, bus_a.RUNNING); end
    end
  endtask

  // Inputs that would stop the run and retarget H are presented while CE is low.
  task automatic test_ce_freeze();
    bus_a.CE = 1'b0;
    bus_a.ENABLE = 1'b0;
    bus_a.HALF_PERIOD_IN = 17'd48;
    bus_a.HALF_PERIOD_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (bus_a.OUT_WORD !== 8'h03) begin miscompares++; $display("[TB] FAIL ce_word[%0d]: got %h, expected 03", i, bus_a.OUT_WORD); end
      vectors++;
      if (bus_a.EDGE !== 1'b1 || bus_a.RUNNING !== 1'b1) begin miscompares++; $display("[TB] FAIL ce_flags[%0d]: got edge=%b running=%b, expected 1 1", i, bus_a.EDGE, bus_a.RUNNING); end
    end
    bus_a.CE = 1'b1;
    bus_a.ENABLE = 1'b1;
    bus_a.HALF_PERIOD_VALID = 1'b0;
    for (int i = 2; i < 7; i++) begin
      step();
      vectors++;
      if (bus_a.OUT_WORD !== int_words[i%5]) begin miscompares++; $display("[TB] FAIL ce_resume[%0d]: got %h, expected %h", i, bus_a.OUT_WORD, int_words[i%5]); end
    end
    vectors++;
    if (bus_a.HALF_PERIOD_CUR !== 17'd160) begin miscompares++; $display("[TB] FAIL ce_cur: got %0d, expected 160", bus_a.HALF_PERIOD_CUR); end
  endtask

  task automatic test_stop();
    // Low level with a rising edge pending: stop at once, nothing emitted.
    bus_a.ENABLE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (bus_a.OUT_WORD !== 8'h00 || bus_a.RUNNING !== 1'b0 || bus_a.EDGE !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stop_low[%0d]: got word=%h running=%b edge=%b, expected 00 0 0", i, bus_a.OUT_WORD, bus_a.RUNNING, bus_a.EDGE);
      end
    end
    bus_a.ENABLE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (bus_a.OUT_WORD !== int_words[i]) begin miscompares++; $display("[TB] FAIL stop_restart[%0d]: got %h, expected %h", i, bus_a.OUT_WORD, int_words[i]); end
    end
    // High level: F0 then 3F completes a 10-slot pulse before idling.
    bus_a.ENABLE = 1'b0;
    step();
    vectors++;
    if (bus_a.OUT_WORD !== 8'h3F) begin miscompares++; $display("[TB] FAIL stop_tail_word: got %h, expected 3f", bus_a.OUT_WORD); end
    vectors++;
    if (bus_a.EDGE !== 1'b1 || bus_a.RUNNING !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_tail_flags: got edge=%b running=%b, expected 1 0", bus_a.EDGE, bus_a.RUNNING); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (bus_a.OUT_WORD !== 8'h00 || bus_a.RUNNING !== 1'b0 || bus_a.EDGE !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stop_idle[%0d]: got word=%h running=%b edge=%b, expected 00 0 0", i, bus_a.OUT_WORD, bus_a.RUNNING, bus_a.EDGE);
      end
    end
    bus_a.ENABLE = 1'b1;
    step();
    vectors++;
    if (bus_a.OUT_WORD !== 8'hFF || bus_a.RUNNING !== 1'b1) begin miscompares++; $display("[TB] FAIL stop_reenable: got word=%h running=%b, expected ff 1", bus_a.OUT_WORD, bus_a.RUNNING); end
  endtask

  task automatic test_reset_mid_run();
    step();
    vectors++;
    if (bus_a.OUT_WORD !== 8'h03) begin miscompares++; $display("[TB] FAIL rst_pre_word: got %h, expected 03", bus_a.OUT_WORD); end
    RESET = 1'b1;
    step();
    vectors++;
    if (bus_a.OUT_WORD !== 8'h00 || bus_a.RUNNING !== 1'b0 || bus_a.EDGE !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid: got word=%h running=%b edge=%b, expected 00 0 0", bus_a.OUT_WORD, bus_a.RUNNING, bus_a.EDGE);
    end
    RESET = 1'b0;
    step();
    vectors++;
    if (bus_a.OUT_WORD !== 8'hFF || bus_a.RUNNING !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_restart: got word=%h running=%b, expected ff 1", bus_a.OUT_WORD, bus_a.RUNNING); end
  endtask

  // H = 8.5 slots: 17 words = 136 slots = 8 periods = 16 transitions.
  task automatic test_fractional();
    logic prev_bit;
    int   trans, edges, ones, multi, word_trans;
    bus_a.HALF_PERIOD_IN = 17'd136;
    bus_a.HALF_PERIOD_VALID = 1'b1;
    step();
    bus_a.HALF_PERIOD_VALID = 1'b0;
    for (int i = 0; i < 12; i++) step();
    prev_bit = bus_a.OUT_WORD[N-1];
    trans = 0; edges = 0; ones = 0; multi = 0;
    for (int i = 0; i < 17; i++) begin
      step();
      word_trans = 0;
      for (int j = 0; j < N; j++) begin
        if (bus_a.OUT_WORD[j] !== prev_bit) word_trans++;
        if (bus_a.OUT_WORD[j] === 1'b1) ones++;
        prev_bit = bus_a.OUT_WORD[j];
      end
      trans += word_trans;
      if (word_trans > 1) multi++;
      if (bus_a.EDGE === 1'b1) edges++;
    end
    vectors++;
    if (trans != 16) begin miscompares++; $display("[TB] FAIL frac_transitions: got %0d, expected 16", trans); end
    vectors++;
    if (edges != 16) begin miscompares++; $display("[TB] FAIL frac_edges: got %0d, expected 16", edges); end
    vectors++;
    if (multi != 0) begin miscompares++; $display("[TB] FAIL frac_double_edge: got %0d cycles, expected 0", multi); end
    vectors++;
    if (ones != 64 && ones != 72) begin miscompares++; $display("[TB] FAIL frac_ones: got %0d, expected 64 or 72", ones); end
    vectors++;
    if (bus_a.HALF_PERIOD_CUR !== 17'd136) begin miscompares++; $display("[TB] FAIL frac_cur: got %0d, expected 136", bus_a.HALF_PERIOD_CUR); end
  endtask

  task automatic test_clamping();
    bus_a.HALF_PERIOD_IN = 17'd48;
    bus_a.HALF_PERIOD_VALID = 1'b1;
    step();
    bus_a.HALF_PERIOD_VALID = 1'b0;
    for (int i = 0; i < 50 && bus_a.HALF_PERIOD_CUR === 17'd136; i++) step();
    vectors++;
    if (bus_a.HALF_PERIOD_CUR !== 17'd128) begin miscompares++; $display("[TB] FAIL clamp_min: got %0d, expected 128", bus_a.HALF_PERIOD_CUR); end
    bus_a.HALF_PERIOD_IN = 17'd80000;
    bus_a.HALF_PERIOD_VALID = 1'b1;
    step();
    bus_a.HALF_PERIOD_VALID = 1'b0;
    for (int i = 0; i < 50 && bus_a.HALF_PERIOD_CUR === 17'd128; i++) step();
    vectors++;
    if (bus_a.HALF_PERIOD_CUR !== 17'd16000) begin miscompares++; $display("[TB] FAIL clamp_max: got %0d, expected 16000", bus_a.HALF_PERIOD_CUR); end
  endtask

  // 100.0 -> 200.0 with shift 2: 2000 (125.0), 2300 (143.75), ... 3197, then snap to 3200.
  task automatic test_smoothing();
    int exp_h, seen, updates, diff;
    int first [2];
    bus_b.ENABLE = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus_b.HALF_PERIOD_IN = 14'd3200;
    bus_b.HALF_PERIOD_VALID = 1'b1;
    step();
    bus_b.HALF_PERIOD_VALID = 1'b0;
    exp_h = 1600; seen = 1600; updates = 0;
    first[0] = 0; first[1] = 0;
    for (int i = 0; i < 2000 && exp_h != 3200; i++) begin
      step();
      if (int'(bus_b.HALF_PERIOD_CUR) != seen) begin
        diff  = 3200 - exp_h;
        exp_h = (diff < 4) ? 3200 : exp_h + (diff >>> 2);
        vectors++;
        if (bus_b.HALF_PERIOD_CUR !== 14'(exp_h)) begin miscompares++; $display("[TB] FAIL smooth_step[%0d]: got %0d, expected %0d", updates, bus_b.HALF_PERIOD_CUR, exp_h); end
        vectors++;
        if (bus_b.EDGE !== 1'b1) begin miscompares++; $display("[TB] FAIL smooth_on_edge[%0d]: got %b, expected 1", updates, bus_b.EDGE); end
        if (updates < 2) first[updates] = int'(bus_b.HALF_PERIOD_CUR);
        seen = int'(bus_b.HALF_PERIOD_CUR);
        updates++;
      end
    end
    vectors++;
    if (first[0] != 2000 || first[1] != 2300) begin miscompares++; $display("[TB] FAIL smooth_first: got %0d %0d, expected 2000 2300", first[0], first[1]); end
    vectors++;
    if (updates != 25) begin miscompares++; $display("[TB] FAIL smooth_updates: got %0d, expected 25", updates); end
    vectors++;
    if (bus_b.HALF_PERIOD_CUR !== 14'd3200) begin miscompares++; $display("[TB] FAIL smooth_final: got %0d, expected 3200", bus_b.HALF_PERIOD_CUR); end
  endtask

  initial begin
    RESET = 1'b1;
    bus_a.CE = 1'b1;
    bus_a.ENABLE = 1'b0;
    bus_a.HALF_PERIOD_IN = '0;
    bus_a.HALF_PERIOD_VALID = 1'b0;
    bus_b.CE = 1'b1;
    bus_b.ENABLE = 1'b0;
    bus_b.HALF_PERIOD_IN = '0;
    bus_b.HALF_PERIOD_VALID = 1'b0;

    test_reset();
    test_integer();
    test_ce_freeze();
    test_stop();
    test_reset_mid_run();
    test_fractional();
    test_clamping();
    test_smoothing();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
